// File: rtl/riscv_pkg.sv
// Shared RV32I controller constants: opcode encodings and control-field encodings
// used by the main decoder, ALU decoder and immediate extender.
package riscv_pkg;

  localparam int unsigned OP_W = 7;

  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OP_W-1:0] OP_ITYPE  = 7'b0010011;
  localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

endpackage

// File: rtl/op_decoder.sv
// Main control decoder: opcode to datapath controls, plus a sticky flag that
// records any unsupported opcode seen since reset.
module op_decoder
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [OP_W-1:0] op,
  output logic [1:0]      ResultSrc,
  output logic [1:0]      ImmSrc,
  output logic [1:0]      ALUOp,
  output logic            MemWrite,
  output logic            Branch,
  output logic            ALUSrc,
  output logic            RegWrite,
  output logic            Jump,
  output logic            Illegal,
  output logic            IllegalSeen
);

  logic illegal_seen_q;
  logic illegal_seen_d;

  // Zero-latency decode; unlisted opcodes leave every control at 0.
  always_comb begin
    ResultSrc = RES_ALU;
    ImmSrc    = IMM_I;
    ALUOp     = ALUOP_ADD;
    MemWrite  = 1'b0;
    Branch    = 1'b0;
    ALUSrc    = 1'b0;
    RegWrite  = 1'b0;
    Jump      = 1'b0;
    Illegal   = 1'b0;
    case (op)
      OP_LOAD: begin
        RegWrite  = 1'b1;
        ALUSrc    = 1'b1;
        ResultSrc = RES_MEM;
      end
      OP_STORE: begin
        ImmSrc   = IMM_S;
        ALUSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      OP_RTYPE: begin
        RegWrite = 1'b1;
        ALUOp    = ALUOP_FUNCT;
      end
      OP_BRANCH: begin
        ImmSrc = IMM_B;
        Branch = 1'b1;
        ALUOp  = ALUOP_SUB;
      end
      OP_ITYPE: begin
        RegWrite = 1'b1;
        ALUSrc   = 1'b1;
        ALUOp    = ALUOP_FUNCT;
      end
      OP_JAL: begin
        RegWrite  = 1'b1;
        ImmSrc    = IMM_J;
        ResultSrc = RES_PC4;
        Jump      = 1'b1;
      end
      default: Illegal = 1'b1;
    endcase
  end

  always_comb begin
    illegal_seen_d = illegal_seen_q | Illegal;
  end

  // Sticky debug flag; reset wins over a simultaneous set.
  always_ff @(posedge clk) begin
    if (reset) illegal_seen_q <= 1'b0;
    else       illegal_seen_q <= illegal_seen_d;
  end

  assign IllegalSeen = illegal_seen_q;

endmodule

// File: tb/tb_op_decoder.sv
// Directed self-checking bench for op_decoder.
`timescale 1ns/1ps
module tb_op_decoder;

  logic       clk;
  logic       reset;
  logic [6:0] op;
  logic [1:0] ResultSrc, ImmSrc, ALUOp;
  logic       MemWrite, Branch, ALUSrc, RegWrite, Jump, Illegal, IllegalSeen;

  int n_pass  = 0;
  int n_total = 0;

  // {RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp, Jump}
  logic [10:0] ctrl;
  assign ctrl = {RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp, Jump};

  op_decoder dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .ResultSrc  (ResultSrc),
    .ImmSrc     (ImmSrc),
    .ALUOp      (ALUOp),
    .MemWrite   (MemWrite),
    .Branch     (Branch),
    .ALUSrc     (ALUSrc),
    .RegWrite   (RegWrite),
    .Jump       (Jump),
    .Illegal    (Illegal),
    .IllegalSeen(IllegalSeen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b1;
    op    = 7'b0000000;
    @(posedge clk);
    @(posedge clk);
    #1;
    n_total++;
    if (IllegalSeen !== 1'b0) $display("FAIL reset_seen: got %b want 0", IllegalSeen);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    op    = 7'b0000011;
    #1;
    n_total++;
    if (ctrl !== 11'b1_00_1_0_01_0_00_0 || Illegal !== 1'b0)
      $display("FAIL lw_decode: got ctrl=%b ill=%b want 10010010000 ill=0", ctrl, Illegal);
    else n_pass++;
    @(posedge clk);
    #1;
    n_total++;
    if (IllegalSeen !== 1'b0) $display("FAIL lw_seen: got %b want 0", IllegalSeen);
    else n_pass++;
  endtask

  task automatic test_sequence();
    logic [6:0]  ops [6];
    logic [10:0] exp [6];
    ops = '{7'b0100011, 7'b0110011, 7'b1100011, 7'b0010011, 7'b1101111, 7'b0110011};
    exp = '{11'b0_01_1_1_00_0_00_0,
            11'b1_00_0_0_00_0_10_0,
            11'b0_10_0_0_00_1_01_0,
            11'b1_00_1_0_00_0_10_0,
            11'b1_11_0_0_10_0_00_1,
            11'b1_00_0_0_00_0_10_0};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      op = ops[i];
      #1;
      n_total++;
      if (ctrl !== exp[i] || Illegal !== 1'b0)
        $display("FAIL seq_%0d op=%b: got ctrl=%b ill=%b want ctrl=%b ill=0",
                 i, ops[i], ctrl, Illegal, exp[i]);
      else n_pass++;
      if (i == 0) begin
        n_total++;
        if (MemWrite !== 1'b1 || RegWrite !== 1'b0)
          $display("FAIL sw_write: got mw=%b rw=%b want mw=1 rw=0", MemWrite, RegWrite);
        else n_pass++;
      end
      if (i == 4) begin
        n_total++;
        if (Jump !== 1'b1 || ResultSrc !== 2'b10)
          $display("FAIL jal_jump: got j=%b rs=%b want j=1 rs=10", Jump, ResultSrc);
        else n_pass++;
      end
      #9;
      @(negedge clk);
    end
  endtask

  task automatic test_illegal();
    @(negedge clk);
    op = 7'b1111111;
    #1;
    n_total++;
    if (ctrl !== 11'b0 || Illegal !== 1'b1)
      $display("FAIL illegal_decode: got ctrl=%b ill=%b want ctrl=0 ill=1", ctrl, Illegal);
    else n_pass++;
    n_total++;
    if (IllegalSeen !== 1'b0) $display("FAIL seen_before_edge: got %b want 0", IllegalSeen);
    else n_pass++;
    @(posedge clk);
    #1;
    n_total++;
    if (IllegalSeen !== 1'b1) $display("FAIL seen_set: got %b want 1", IllegalSeen);
    else n_pass++;
    @(negedge clk);
    op = 7'b0110011;
    #1;
    n_total++;
    if (Illegal !== 1'b0) $display("FAIL legal_after_illegal: got ill=%b want 0", Illegal);
    else n_pass++;
    @(posedge clk);
    @(posedge clk);
    #1;
    n_total++;
    if (IllegalSeen !== 1'b1) $display("FAIL seen_sticky: got %b want 1", IllegalSeen);
    else n_pass++;
  endtask

  task automatic test_reset_priority();
    @(negedge clk);
    reset = 1'b1;
    op    = 7'b0000000;
    #1;
    n_total++;
    if (Illegal !== 1'b1 || ctrl !== 11'b0)
      $display("FAIL decode_in_reset: got ctrl=%b ill=%b want ctrl=0 ill=1", ctrl, Illegal);
    else n_pass++;
    @(posedge clk);
    #1;
    n_total++;
    if (IllegalSeen !== 1'b0) $display("FAIL reset_wins: got %b want 0", IllegalSeen);
    else n_pass++;
    @(negedge clk);
    op    = 7'b0000011;
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_total++;
    if (IllegalSeen !== 1'b0) $display("FAIL seen_after_reset: got %b want 0", IllegalSeen);
    else n_pass++;
  endtask

  task automatic test_sweep();
    int legal_cnt = 0;
    for (int i = 0; i < 128; i++) begin
      op = 7'(i);
      #1;
      n_total++;
      if ((^{ctrl, Illegal, IllegalSeen}) === 1'bx)
        $display("FAIL sweep_x op=%b: got ctrl=%b ill=%b", op, ctrl, Illegal);
      else n_pass++;
      n_total++;
      if (MemWrite !== (op == 7'b0100011))
        $display("FAIL sweep_memwrite op=%b: got %b want %b", op, MemWrite, op == 7'b0100011);
      else n_pass++;
      n_total++;
      if (Branch !== (op == 7'b1100011))
        $display("FAIL sweep_branch op=%b: got %b want %b", op, Branch, op == 7'b1100011);
      else n_pass++;
      if (Illegal === 1'b1) begin
        n_total++;
        if (ctrl !== 11'b0) $display("FAIL sweep_illegal_zero op=%b: got ctrl=%b want 0", op, ctrl);
        else n_pass++;
      end else begin
        legal_cnt++;
      end
      #1;
    end
    n_total++;
    if (legal_cnt != 6) $display("FAIL sweep_legal_count: got %0d want 6", legal_cnt);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_illegal();
    test_reset_priority();
    test_sweep();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
